tag_array_nway: RTL and testbench

TAG_ARRAY_NWAY -- requirements
Module: tag_array_nway

---
 rtl/tag_array_nway.sv | 202 ++++++++++++++++++++
 tb/tb_tag_array_nway.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_array_nway.sv
// N-way set-associative tag store with per-set age-based LRU and an init sweep after reset.
// Define TAG_ARRAY_NWAY_PARITY_EN to add per-entry even parity and the parity_err output.
module tag_array_nway #(
    parameter int WAYS  = 4,
    parameter int SETS  = 128,
    parameter int TAG_W = 19,
    localparam int WAY_W = $clog2(WAYS),
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             valid_in,
    input  logic             dirty_in,
    input  logic             write_en,
    input  logic [WAY_W-1:0] write_way,
    input  logic             update_lru,
    input  logic [WAY_W-1:0] accessed_way,
    output logic             ready,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic             multi_hit,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_valid,
    output logic             victim_dirty,
`ifdef TAG_ARRAY_NWAY_PARITY_EN
    output logic             parity_err,
`endif
    output logic [TAG_W-1:0] victim_tag
);

    typedef enum logic {StInit, StReady} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;

    // Storage arrays carry no reset; the init sweep is the only way they get cleared.
    logic [WAYS-1:0][TAG_W-1:0] tag_mem_q   [SETS];
    logic [WAYS-1:0]            valid_mem_q [SETS];
    logic [WAYS-1:0]            dirty_mem_q [SETS];
    logic [WAYS-1:0][WAY_W-1:0] age_mem_q   [SETS];

    logic [WAYS-1:0][TAG_W-1:0] rd_tag;
    logic [WAYS-1:0]            rd_valid;
    logic [WAYS-1:0]            rd_dirty;
    logic [WAYS-1:0][WAY_W-1:0] rd_age;

    logic                       row_we;
    logic [IDX_W-1:0]           row_idx;
    logic [WAYS-1:0][TAG_W-1:0] row_tag_d;
    logic [WAYS-1:0]            row_valid_d;
    logic [WAYS-1:0]            row_dirty_d;
    logic [WAYS-1:0][WAY_W-1:0] row_age_d;

    logic [WAYS-1:0]            match;
    logic [WAYS-1:0]            par_bad;

`ifdef TAG_ARRAY_NWAY_PARITY_EN
    logic [WAYS-1:0]            par_mem_q [SETS];
    logic [WAYS-1:0]            rd_par;
    logic [WAYS-1:0]            row_par_d;
`endif

    assign rd_tag   = tag_mem_q[index];
    assign rd_valid = valid_mem_q[index];
    assign rd_dirty = dirty_mem_q[index];
    assign rd_age   = age_mem_q[index];
`ifdef TAG_ARRAY_NWAY_PARITY_EN
    assign rd_par   = par_mem_q[index];
`endif

    // Control FSM and sweep counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StInit;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ready   = (state_q == StReady);
        if (state_q == StInit) begin
            sweep_d = sweep_q + IDX_W'(1);
            if (sweep_q == IDX_W'(SETS - 1)) begin
                state_d = StReady;
            end
        end
    end

    // Row update: the whole set is rewritten so a write and an LRU update can merge in one edge.
    always_comb begin
        row_we      = 1'b0;
        row_idx     = index;
        row_tag_d   = rd_tag;
        row_valid_d = rd_valid;
        row_dirty_d = rd_dirty;
        row_age_d   = rd_age;
`ifdef TAG_ARRAY_NWAY_PARITY_EN
        row_par_d   = rd_par;
`endif
        if (state_q == StInit) begin
            row_we      = 1'b1;
            row_idx     = sweep_q;
            row_tag_d   = '0;
            row_valid_d = '0;
            row_dirty_d = '0;
            for (int w = 0; w < WAYS; w++) begin
                row_age_d[w] = WAY_W'(w);
            end
`ifdef TAG_ARRAY_NWAY_PARITY_EN
            row_par_d   = '0;
`endif
        end else begin
            if (write_en) begin
                row_we                 = 1'b1;
                row_tag_d[write_way]   = tag_in;
                row_valid_d[write_way] = valid_in;
                row_dirty_d[write_way] = dirty_in;
`ifdef TAG_ARRAY_NWAY_PARITY_EN
                row_par_d[write_way]   = ^{tag_in, valid_in, dirty_in};
`endif
            end
            if (update_lru) begin
                row_we = 1'b1;
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == accessed_way) begin
                        row_age_d[w] = '0;
                    end else if (rd_age[w] < rd_age[accessed_way]) begin
                        row_age_d[w] = rd_age[w] + WAY_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (row_we) begin
            tag_mem_q[row_idx]   <= row_tag_d;
            valid_mem_q[row_idx] <= row_valid_d;
            dirty_mem_q[row_idx] <= row_dirty_d;
            age_mem_q[row_idx]   <= row_age_d;
`ifdef TAG_ARRAY_NWAY_PARITY_EN
            par_mem_q[row_idx]   <= row_par_d;
`endif
        end
    end

    // Lookup
    always_comb begin
        par_bad = '0;
        match   = '0;
        for (int w = 0; w < WAYS; w++) begin
`ifdef TAG_ARRAY_NWAY_PARITY_EN
            par_bad[w] = rd_par[w] ^ (^{rd_tag[w], rd_valid[w], rd_dirty[w]});
`endif
            match[w] = rd_valid[w] && (rd_tag[w] == tag_in) && !par_bad[w];
        end
        hit       = ready && (|match);
        // Clearing the lowest set bit leaves something only when two or more ways match.
        multi_hit = ready && (|(match & (match - WAYS'(1))));
        hit_way   = '0;
        if (ready) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (match[w]) begin
                    hit_way = WAY_W'(w);
                end
            end
        end
    end

`ifdef TAG_ARRAY_NWAY_PARITY_EN
    assign parity_err = |par_bad;
`endif

    // Victim selection: free ways first, else the oldest way
    always_comb begin
        victim_way = '0;
        if (&rd_valid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (rd_age[w] == WAY_W'(WAYS - 1)) begin
                    victim_way = WAY_W'(w);
                end
            end
        end else begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (!rd_valid[w]) begin
                    victim_way = WAY_W'(w);
                end
            end
        end
        victim_valid = rd_valid[victim_way];
        victim_dirty = rd_dirty[victim_way];
        victim_tag   = rd_tag[victim_way];
    end

endmodule

// File: tb/tb_tag_array_nway.sv
// Self-checking bench for tag_array_nway: directed vector table, reset/init sequences and
// randomized traffic checked against a recency-list reference model.
module tb_tag_array_nway;

    localparam int WAYS  = 4;
    localparam int SETS  = 128;
    localparam int TAG_W = 19;
    localparam int WAY_W = 2;
    localparam int IDX_W = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag_in;
    logic             valid_in, dirty_in, write_en, update_lru;
    logic [WAY_W-1:0] write_way, accessed_way;
    logic             ready, hit, multi_hit;
    logic [WAY_W-1:0] hit_way, victim_way;
    logic             victim_valid, victim_dirty;
    logic [TAG_W-1:0] victim_tag;
`ifdef TAG_ARRAY_NWAY_PARITY_EN
    logic             parity_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tag_array_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .index        (index),
        .tag_in       (tag_in),
        .valid_in     (valid_in),
        .dirty_in     (dirty_in),
        .write_en     (write_en),
        .write_way    (write_way),
        .update_lru   (update_lru),
        .accessed_way (accessed_way),
        .ready        (ready),
        .hit          (hit),
        .hit_way      (hit_way),
        .multi_hit    (multi_hit),
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
`ifdef TAG_ARRAY_NWAY_PARITY_EN
        .parity_err   (parity_err),
`endif
        .victim_tag   (victim_tag)
    );

    // Reference model: contents per way plus a recency list per set (MRU first, LRU last).
    logic [TAG_W-1:0] m_tag   [SETS][WAYS];
    bit               m_valid [SETS][WAYS];
    bit               m_dirty [SETS][WAYS];
    int               m_order [SETS][WAYS];

    typedef struct {
        int idx; int tag; bit we; int ww; bit v; bit d; bit ul; int aw;
        bit e_hit; int e_hw; bit e_mh; int e_vw; bit e_vv;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(int idx, int tag, bit we, int ww, bit v, bit d, bit ul, int aw,
                                bit h, int hw, bit mh, int vw, bit vv);
        vec_t r;
        r.idx = idx; r.tag = tag; r.we = we; r.ww = ww; r.v = v; r.d = d; r.ul = ul; r.aw = aw;
        r.e_hit = h; r.e_hw = hw; r.e_mh = mh; r.e_vw = vw; r.e_vv = vv;
        return r;
    endfunction

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_tag[s][w] = '0; m_valid[s][w] = 0; m_dirty[s][w] = 0; m_order[s][w] = w;
            end
        end
    endtask

    task automatic model_step(input int s, input logic [TAG_W-1:0] t, input bit we, input int ww,
                              input bit v, input bit d, input bit ul, input int aw);
        int p;
        if (ul) begin
            p = 0;
            for (int i = 0; i < WAYS; i++) if (m_order[s][i] == aw) p = i;
            for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
            m_order[s][0] = aw;
        end
        if (we) begin
            m_tag[s][ww] = t; m_valid[s][ww] = v; m_dirty[s][ww] = d;
        end
    endtask

    task automatic model_lookup(input int s, input logic [TAG_W-1:0] t, output bit h,
                                output int hw, output bit mh, output int vw);
        int n;
        n = 0; hw = 0; vw = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                if (n == 0) hw = w;
                n++;
            end
            if (!m_valid[s][w] && vw < 0) vw = w;
        end
        if (vw < 0) vw = m_order[s][WAYS-1];
        h = (n > 0); mh = (n > 1);
    endtask

    task automatic drive(input int i, input int t, input bit we, input int ww, input bit v,
                         input bit d, input bit ul, input int aw);
        index = IDX_W'(i); tag_in = TAG_W'(t); write_en = we; write_way = WAY_W'(ww);
        valid_in = v; dirty_in = d; update_lru = ul; accessed_way = WAY_W'(aw);
    endtask

    // Commit the driven inputs at the next edge, mirror them in the model, then settle.
    task automatic commit();
        @(posedge clk);
        model_step(int'(index), tag_in, write_en, int'(write_way), valid_in, dirty_in,
                   update_lru, int'(accessed_way));
        #1;
    endtask

    // Counts edges after reset release until ready; optionally pokes writes while in INIT.
    task automatic wait_ready(input bit poke, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 10) begin
                #1;
                check("init_hit_forced", int'(hit), 0);
                check("init_mhit_forced", int'(multi_hit), 0);
            end
            if (poke && n == 20) drive(0, 'h55, 1, 1, 1, 1, 1, 3);
            if (poke && n == 21) drive(0, 0, 0, 0, 0, 0, 0, 0);
        end while (!ready && n < 300);
    endtask

    initial begin
        int n;
        bit e_h, e_mh;
        int e_hw, e_vw;

        vecs[0]  = mk(5,  'h1234, 1, 2, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[1]  = mk(5,  'h1234, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0, 0);
        vecs[2]  = mk(6,  'h1234, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[3]  = mk(9,  'h100,  1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        vecs[4]  = mk(9,  'h101,  1, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
        vecs[5]  = mk(9,  'h102,  1, 2, 1, 0, 0, 0,  0, 0, 0, 2, 0);
        vecs[6]  = mk(9,  'h103,  1, 3, 1, 1, 0, 0,  0, 0, 0, 3, 0);
        vecs[7]  = mk(9,  'h100,  0, 0, 0, 0, 1, 3,  1, 0, 0, 3, 1);
        vecs[8]  = mk(9,  'h101,  0, 0, 0, 0, 1, 1,  1, 1, 0, 2, 1);
        vecs[9]  = mk(9,  'h102,  0, 0, 0, 0, 1, 0,  1, 2, 0, 2, 1);
        vecs[10] = mk(9,  'h103,  0, 0, 0, 0, 1, 2,  1, 3, 0, 2, 1);
        vecs[11] = mk(9,  'h999,  0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 1);
        vecs[12] = mk(9,  'h999,  0, 0, 0, 0, 1, 3,  0, 0, 0, 3, 1);
        vecs[13] = mk(9,  'h999,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
        vecs[14] = mk(12, 'h77,   1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[15] = mk(12, 'h77,   1, 3, 1, 0, 0, 0,  1, 1, 0, 0, 0);
        vecs[16] = mk(12, 'h77,   0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0);
        vecs[17] = mk(12, 'h77,   1, 0, 1, 0, 1, 2,  1, 1, 1, 0, 0);
        vecs[18] = mk(12, 'h77,   0, 0, 0, 0, 0, 0,  1, 0, 1, 2, 0);
        vecs[19] = mk(12, 'h55,   1, 2, 1, 0, 0, 0,  0, 0, 0, 2, 0);
        vecs[20] = mk(12, 'h55,   0, 0, 0, 0, 0, 0,  1, 2, 0, 3, 1);
        vecs[21] = mk(12, 'h77,   1, 1, 0, 0, 0, 0,  1, 0, 1, 3, 1);
        vecs[22] = mk(12, 'h77,   0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 0);

        // Reset and first init sweep, with writes/LRU updates poked in mid-sweep.
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(ready), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_mhit", int'(multi_hit), 0);
        #2 rst = 1'b1;
        wait_ready(1, n);
        check("init_cycles", n, 128);
        model_reset();
        for (int s = 0; s < SETS; s++) begin
            drive(s, 0, 0, 0, 0, 0, 0, 0);
            #1;
            check($sformatf("sweep_set%0d", s),
                  int'({hit, victim_way, victim_valid, victim_dirty}), 0);
        end
        drive(0, 'h55, 0, 0, 0, 0, 0, 0);
        #1;
        check("init_write_ignored", int'(hit), 0);
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].idx, vecs[i].tag, vecs[i].we, vecs[i].ww, vecs[i].v, vecs[i].d,
                  vecs[i].ul, vecs[i].aw);
            #2;
            check($sformatf("v%0d_hit", i), int'(hit), int'(vecs[i].e_hit));
            check($sformatf("v%0d_hway", i), int'(hit_way), vecs[i].e_hw);
            check($sformatf("v%0d_mhit", i), int'(multi_hit), int'(vecs[i].e_mh));
            check($sformatf("v%0d_vway", i), int'(victim_way), vecs[i].e_vw);
            check($sformatf("v%0d_vvalid", i), int'(victim_valid), int'(vecs[i].e_vv));
            commit();
        end

        // Randomized traffic on a few sets with a small tag pool
        for (int k = 0; k < 600; k++) begin
            drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)));
            #2;
            model_lookup(int'(index), tag_in, e_h, e_hw, e_mh, e_vw);
            check("rnd_hit", int'(hit), int'(e_h));
            check("rnd_hway", int'(hit_way), e_hw);
            check("rnd_mhit", int'(multi_hit), int'(e_mh));
            check("rnd_vway", int'(victim_way), e_vw);
            check("rnd_vvalid", int'(victim_valid), int'(m_valid[int'(index)][e_vw]));
            check("rnd_vdirty", int'(victim_dirty), int'(m_dirty[int'(index)][e_vw]));
            check("rnd_vtag", int'(victim_tag), int'(m_tag[int'(index)][e_vw]));
            commit();
        end

        // Reset while READY, then again mid-sweep at set 40
        drive(12, 'h77, 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", int'(ready), 0);
        check("rst_in_ready_hit", int'(hit), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midinit_ready", int'(ready), 0);
        rst = 1'b0;
        #1;
        check("midinit_rst_ready", int'(ready), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        wait_ready(0, n);
        check("reinit_cycles", n, 128);
        model_reset();
        drive(12, 'h77, 0, 0, 0, 0, 0, 0);
        #1;
        check("reinit_set12_hit", int'(hit), 0);
        check("reinit_set12_vvalid", int'(victim_valid), 0);
        drive(9, 'h100, 0, 0, 0, 0, 0, 0);
        #1;
        check("reinit_set9_hit", int'(hit), 0);
        check("reinit_set9_vway", int'(victim_way), 0);

`ifdef TAG_ARRAY_NWAY_PARITY_EN
        drive(5, 'h1234, 1, 2, 1, 0, 0, 0);
        commit();
        drive(5, 'h1234, 0, 0, 0, 0, 0, 0);
        #1;
        check("par_clean_hit", int'(hit), 1);
        check("par_clean_err", int'(parity_err), 0);
        dut.tag_mem_q[5][2][0] = ~dut.tag_mem_q[5][2][0];
        tag_in = 19'h1235;
        #1;
        check("par_flip_hit", int'(hit), 0);
        check("par_flip_err", int'(parity_err), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
